dbi_tx_sequencer: RTL and testbench

- Downstream consumer of the AXI4 configuration register block; drives a MIPI DBI Type-B (8080-style, 8-bit) write-only panel interface.
- On a start request it:
  - snapshots the command/parameter bytes;
  - issues soft-reset, reset-wait, display-on, column-address, row-address and memory-write commands;
  - streams a fixed number of pixel bytes from a valid/ready pixel source.

---
 rtl/dbi_tx_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_dbi_tx_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbi_tx_sequencer.sv
// Purpose : MIPI DBI Type-B (8080, 8-bit) write-only panel sequencer: on a start
//           edge, sends the panel init/address commands, then streams one frame of pixel bytes.
// Latency : the first byte slot starts the cycle after the start edge; each byte slot is
//           2*HALF_CYC cycles, and each pixel slot is preceded by at least one ready cycle.
// Backpressure: pxl_rdy_o is high only at pixel slot boundaries; while pxl_vld_i is low the
//           bus holds with wrx high and the frame simply stretches.
// Optional: `define DBI_TX_CONTINUOUS_EN to loop MWR_CMD + pixels while start stays high at DONE.
// Ports   : clk/rst_n (async active-low); dbi_tx_start_i level (rising edge = start);
//           addr_*_i command codes and cmd_*_i column/row parameters (sampled on start);
//           pxl_data_i/pxl_vld_i/pxl_rdy_o pixel stream; dbi_csx_o/dbi_dcx_o/dbi_wrx_o/dbi_d_o
//           panel bus (all registered); busy_o frame in progress; frame_done_o 1-cycle pulse.
module dbi_tx_sequencer #(
  parameter int DATA_W      = 8,
  parameter int CONF_DATA_W = 8,
  parameter int HALF_CYC    = 2,
  parameter int RST_DLY_CYC = 16,
  parameter int PIXEL_BYTES = 153600
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dbi_tx_start_i,
  input  logic [CONF_DATA_W-1:0] addr_soft_rst_i,
  input  logic [CONF_DATA_W-1:0] addr_disp_on_i,
  input  logic [CONF_DATA_W-1:0] addr_col_i,
  input  logic [CONF_DATA_W-1:0] addr_row_i,
  input  logic [CONF_DATA_W-1:0] addr_mem_wr_i,
  input  logic [CONF_DATA_W-1:0] cmd_s_col_h_i,
  input  logic [CONF_DATA_W-1:0] cmd_s_col_l_i,
  input  logic [CONF_DATA_W-1:0] cmd_e_col_h_i,
  input  logic [CONF_DATA_W-1:0] cmd_e_col_l_i,
  input  logic [CONF_DATA_W-1:0] cmd_s_row_h_i,
  input  logic [CONF_DATA_W-1:0] cmd_s_row_l_i,
  input  logic [CONF_DATA_W-1:0] cmd_e_row_h_i,
  input  logic [CONF_DATA_W-1:0] cmd_e_row_l_i,
  input  logic [DATA_W-1:0]      pxl_data_i,
  input  logic                   pxl_vld_i,
  output logic                   pxl_rdy_o,
  output logic                   dbi_csx_o,
  output logic                   dbi_dcx_o,
  output logic                   dbi_wrx_o,
  output logic [DATA_W-1:0]      dbi_d_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam int SCW = $clog2(2 * HALF_CYC + 1);
  localparam int WCW = $clog2(RST_DLY_CYC + 1);
  localparam int PCW = $clog2(PIXEL_BYTES + 1);

  localparam logic [SCW-1:0] SLOT_LAST = SCW'(2 * HALF_CYC - 1);
  localparam logic [SCW-1:0] WRX_RISE  = SCW'(HALF_CYC - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(RST_DLY_CYC - 1);
  localparam logic [PCW-1:0] PIX_LAST  = PCW'(PIXEL_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE, SRST_CMD, RST_WAIT, DISP_CMD, COL_CMD, COL_PRM,
    ROW_CMD, ROW_PRM, MWR_CMD, PIXEL, DONE
  } state_t;

  state_t           state, state_nxt;
  logic [SCW-1:0]   slot_cnt, slot_cnt_nxt;
  logic [WCW-1:0]   wait_cnt, wait_cnt_nxt;
  logic [1:0]       prm_idx, prm_idx_nxt;
  logic [PCW-1:0]   pix_cnt, pix_cnt_nxt;
  logic             csx_nxt, dcx_nxt, wrx_nxt, rdy_nxt, busy_nxt, done_nxt;
  logic [DATA_W-1:0] d_nxt;
  logic             start_q;
  logic             start_edge;

  // Shadow copies of the configuration, frozen at the accepted start edge.
  logic [CONF_DATA_W-1:0] sh_disp_on, sh_col, sh_row, sh_mem_wr;
  logic [CONF_DATA_W-1:0] sh_col_prm [4];
  logic [CONF_DATA_W-1:0] sh_row_prm [4];

  // Slot control: 'step' advances the slot in progress, 'load' starts a new one.
  logic              step, load, load_dcx;
  logic [DATA_W-1:0] load_d;
  logic              slot_end;

  assign start_edge = dbi_tx_start_i & ~start_q;
  assign slot_end   = (slot_cnt == SLOT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
    end else begin
      start_q <= dbi_tx_start_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_disp_on <= '0;
      sh_col     <= '0;
      sh_row     <= '0;
      sh_mem_wr  <= '0;
      for (int i = 0; i < 4; i++) begin
        sh_col_prm[i] <= '0;
        sh_row_prm[i] <= '0;
      end
    end else if (state == IDLE && start_edge) begin
      sh_disp_on    <= addr_disp_on_i;
      sh_col        <= addr_col_i;
      sh_row        <= addr_row_i;
      sh_mem_wr     <= addr_mem_wr_i;
      sh_col_prm[0] <= cmd_s_col_h_i;
      sh_col_prm[1] <= cmd_s_col_l_i;
      sh_col_prm[2] <= cmd_e_col_h_i;
      sh_col_prm[3] <= cmd_e_col_l_i;
      sh_row_prm[0] <= cmd_s_row_h_i;
      sh_row_prm[1] <= cmd_s_row_l_i;
      sh_row_prm[2] <= cmd_e_row_h_i;
      sh_row_prm[3] <= cmd_e_row_l_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      slot_cnt     <= '0;
      wait_cnt     <= '0;
      prm_idx      <= '0;
      pix_cnt      <= '0;
      dbi_csx_o    <= 1'b1;
      dbi_dcx_o    <= 1'b1;
      dbi_wrx_o    <= 1'b1;
      dbi_d_o      <= '0;
      pxl_rdy_o    <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      slot_cnt     <= slot_cnt_nxt;
      wait_cnt     <= wait_cnt_nxt;
      prm_idx      <= prm_idx_nxt;
      pix_cnt      <= pix_cnt_nxt;
      dbi_csx_o    <= csx_nxt;
      dbi_dcx_o    <= dcx_nxt;
      dbi_wrx_o    <= wrx_nxt;
      dbi_d_o      <= d_nxt;
      pxl_rdy_o    <= rdy_nxt;
      busy_o       <= busy_nxt;
      frame_done_o <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    slot_cnt_nxt = slot_cnt;
    wait_cnt_nxt = wait_cnt;
    prm_idx_nxt  = prm_idx;
    pix_cnt_nxt  = pix_cnt;
    csx_nxt      = dbi_csx_o;
    dcx_nxt      = dbi_dcx_o;
    wrx_nxt      = dbi_wrx_o;
    d_nxt        = dbi_d_o;
    rdy_nxt      = pxl_rdy_o;
    busy_nxt     = busy_o;
    done_nxt     = 1'b0;
    step         = 1'b0;
    load         = 1'b0;
    load_dcx     = 1'b1;
    load_d       = '0;

    case (state)
      IDLE: begin
        if (start_edge) begin
          load        = 1'b1;
          load_d      = DATA_W'(addr_soft_rst_i);
          load_dcx    = 1'b0;
          csx_nxt     = 1'b0;
          busy_nxt    = 1'b1;
          pix_cnt_nxt = '0;
          state_nxt   = SRST_CMD;
        end
      end
      SRST_CMD: begin
        step = 1'b1;
        if (slot_end) begin
          wait_cnt_nxt = '0;
          state_nxt    = RST_WAIT;
        end
      end
      RST_WAIT: begin
        // wrx is already high from the tail of the soft-reset slot.
        if (wait_cnt == WAIT_LAST) begin
          load      = 1'b1;
          load_d    = DATA_W'(sh_disp_on);
          load_dcx  = 1'b0;
          state_nxt = DISP_CMD;
        end else begin
          wait_cnt_nxt = wait_cnt + WCW'(1);
        end
      end
      DISP_CMD: begin
        step = 1'b1;
        if (slot_end) begin
          load      = 1'b1;
          load_d    = DATA_W'(sh_col);
          load_dcx  = 1'b0;
          state_nxt = COL_CMD;
        end
      end
      COL_CMD: begin
        step = 1'b1;
        if (slot_end) begin
          load        = 1'b1;
          load_d      = DATA_W'(sh_col_prm[0]);
          prm_idx_nxt = '0;
          state_nxt   = COL_PRM;
        end
      end
      COL_PRM: begin
        step = 1'b1;
        if (slot_end) begin
          load = 1'b1;
          if (prm_idx == 2'd3) begin
            load_d    = DATA_W'(sh_row);
            load_dcx  = 1'b0;
            state_nxt = ROW_CMD;
          end else begin
            load_d      = DATA_W'(sh_col_prm[prm_idx + 2'd1]);
            prm_idx_nxt = prm_idx + 2'd1;
          end
        end
      end
      ROW_CMD: begin
        step = 1'b1;
        if (slot_end) begin
          load        = 1'b1;
          load_d      = DATA_W'(sh_row_prm[0]);
          prm_idx_nxt = '0;
          state_nxt   = ROW_PRM;
        end
      end
      ROW_PRM: begin
        step = 1'b1;
        if (slot_end) begin
          load = 1'b1;
          if (prm_idx == 2'd3) begin
            load_d    = DATA_W'(sh_mem_wr);
            load_dcx  = 1'b0;
            state_nxt = MWR_CMD;
          end else begin
            load_d      = DATA_W'(sh_row_prm[prm_idx + 2'd1]);
            prm_idx_nxt = prm_idx + 2'd1;
          end
        end
      end
      MWR_CMD: begin
        step = 1'b1;
        if (slot_end) begin
          rdy_nxt   = 1'b1;
          state_nxt = PIXEL;
        end
      end
      PIXEL: begin
        // pxl_rdy_o doubles as the "waiting at slot boundary" flag.
        if (pxl_rdy_o) begin
          if (pxl_vld_i) begin
            load    = 1'b1;
            load_d  = pxl_data_i;
            rdy_nxt = 1'b0;
          end
        end else begin
          step = 1'b1;
          if (slot_end) begin
            pix_cnt_nxt = pix_cnt + PCW'(1);
            if (pix_cnt == PIX_LAST) begin
              done_nxt  = 1'b1;
`ifndef DBI_TX_CONTINUOUS_EN
              csx_nxt   = 1'b1;
`endif
              state_nxt = DONE;
            end else begin
              rdy_nxt = 1'b1;
            end
          end
        end
      end
      DONE: begin
        pix_cnt_nxt = '0;
`ifdef DBI_TX_CONTINUOUS_EN
        // Chip select is held low through DONE so a looped frame stays in one transaction.
        if (dbi_tx_start_i) begin
          load      = 1'b1;
          load_d    = DATA_W'(sh_mem_wr);
          load_dcx  = 1'b0;
          state_nxt = MWR_CMD;
        end else begin
          csx_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
`else
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (step) begin
      if (slot_end) begin
        slot_cnt_nxt = '0;
      end else begin
        slot_cnt_nxt = slot_cnt + SCW'(1);
        if (slot_cnt == WRX_RISE) begin
          wrx_nxt = 1'b1;
        end
      end
    end

    if (load) begin
      d_nxt        = load_d;
      dcx_nxt      = load_dcx;
      wrx_nxt      = 1'b0;
      slot_cnt_nxt = '0;
    end
  end

endmodule

// File: tb/tb_dbi_tx_sequencer.sv
module tb_dbi_tx_sequencer;
  localparam int HC = 1;
  localparam int RD = 4;
  localparam int PB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] cfg [13];
  logic [7:0] pxl_data;
  logic       pxl_vld;
  logic       pxl_rdy, csx, dcx, wrx, busy, done;
  logic [7:0] dbus;

  always #5 clk = ~clk;

  dbi_tx_sequencer #(
    .DATA_W(8), .CONF_DATA_W(8), .HALF_CYC(HC), .RST_DLY_CYC(RD), .PIXEL_BYTES(PB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dbi_tx_start_i(start),
    .addr_soft_rst_i(cfg[0]), .addr_disp_on_i(cfg[1]), .addr_col_i(cfg[2]),
    .addr_row_i(cfg[3]), .addr_mem_wr_i(cfg[4]),
    .cmd_s_col_h_i(cfg[5]), .cmd_s_col_l_i(cfg[6]), .cmd_e_col_h_i(cfg[7]), .cmd_e_col_l_i(cfg[8]),
    .cmd_s_row_h_i(cfg[9]), .cmd_s_row_l_i(cfg[10]), .cmd_e_row_h_i(cfg[11]), .cmd_e_row_l_i(cfg[12]),
    .pxl_data_i(pxl_data), .pxl_vld_i(pxl_vld), .pxl_rdy_o(pxl_rdy),
    .dbi_csx_o(csx), .dbi_dcx_o(dcx), .dbi_wrx_o(wrx), .dbi_d_o(dbus),
    .busy_o(busy), .frame_done_o(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- bus monitor (panel view) ----------------
  int         cyc = 0;
  logic       prev_wrx = 1'b1;
  logic [8:0] edges [$];   // {dcx, data} captured at each wrx rising edge
  int         falls [$];   // cycle numbers of wrx falling edges
  int         rdy_cyc, rdy_bad, csx_bad, done_cnt;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (!prev_wrx && wrx) begin
        edges.push_back({dcx, dbus});
        if (csx) csx_bad++;
      end
      if (prev_wrx && !wrx) falls.push_back(cyc);
      if (pxl_rdy) begin
        rdy_cyc++;
        if (!wrx || csx) rdy_bad++;
      end
      if (done) done_cnt++;
    end
    prev_wrx = wrx;
  end

  task automatic mon_clear();
    edges.delete();
    falls.delete();
    rdy_cyc  = 0;
    rdy_bad  = 0;
    csx_bad  = 0;
    done_cnt = 0;
  endtask

  // ---------------- pixel source ----------------
  logic [7:0] pix_q [$];
  int         src_idx = 0;
  int         hs_cnt = 0;
  int         stall_at = -1;
  int         stall_left = 0;
  logic       src_hs;

  initial begin
    pxl_vld  = 1'b0;
    pxl_data = 8'h00;
    forever begin
      @(negedge clk);
      src_hs = pxl_vld && pxl_rdy && rst_n;
      @(posedge clk);
      #1;
      if (src_hs) begin
        src_idx++;
        hs_cnt++;
      end
      if (src_idx < pix_q.size()) begin
        pxl_data = pix_q[src_idx];
        // The stall only counts cycles in which the sequencer is actually asking.
        if (src_idx == stall_at && stall_left > 0 && pxl_rdy) begin
          pxl_vld = 1'b0;
          stall_left--;
        end else begin
          pxl_vld = 1'b1;
        end
      end else begin
        pxl_vld = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [8:0] exp_q [$];

  // Byte list the panel must see, from a config snapshot and the pixel bytes.
  task automatic build_exp(input int first_pix, input bit full_init);
    if (full_init) begin
      exp_q.push_back({1'b0, cfg[0]});
      exp_q.push_back({1'b0, cfg[1]});
      exp_q.push_back({1'b0, cfg[2]});
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, cfg[5 + i]});
      exp_q.push_back({1'b0, cfg[3]});
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, cfg[9 + i]});
    end
    exp_q.push_back({1'b0, cfg[4]});
    for (int k = 0; k < PB; k++) exp_q.push_back({1'b1, pix_q[first_pix + k]});
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("frame_done_timeout", 32'(done_cnt >= target), 1);
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic check_stream(input int n_rdy, input int n_hs, input int n_done);
    chk("edge_count", edges.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < edges.size()) chk($sformatf("edge%0d_dcx_byte", i), 32'(edges[i]), 32'(exp_q[i]));
    end
    chk("rst_wait_gap", (falls.size() > 2) ? falls[1] - falls[0] : -1, 2 * HC + RD);
    chk("cmd_back_to_back", (falls.size() > 2) ? falls[2] - falls[1] : -1, 2 * HC);
    chk("csx_low_at_strobes", csx_bad, 0);
    chk("rdy_only_at_boundary", rdy_bad, 0);
    chk("rdy_cycles", rdy_cyc, n_rdy);
    chk("handshakes", hs_cnt, n_hs);
    chk("done_pulses", done_cnt, n_done);
    chk("csx_after", 32'(csx), 1);
    chk("busy_after", 32'(busy), 0);
    chk("wrx_after", 32'(wrx), 1);
  endtask

  task automatic do_frame(input int s_at, input int s_len, input bit mid_edge, input bit mid_cfg);
    exp_q.delete();
    build_exp(0, 1'b1);
    mon_clear();
    src_idx    = 0;
    hs_cnt     = 0;
    stall_at   = s_at;
    stall_left = s_len;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    if (mid_cfg) cfg[4] = cfg[4] ^ 8'h10;
    chk("busy_mid", 32'(busy), 1);
    @(posedge clk);
    #2 start = 1'b0;
    if (mid_edge) begin
      repeat (10) @(posedge clk);
      #2 start = 1'b1;
      repeat (3) @(posedge clk);
      #2 start = 1'b0;
    end
    wait_done(1);
    check_stream(PB + s_len, PB, 1);
  endtask

  task automatic set_cfg_default();
    logic [7:0] d [13];
    d = '{8'h01, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h00, 8'h00, 8'h00, 8'hEF,
          8'h00, 8'h00, 8'h01, 8'h3F};
    for (int i = 0; i < 13; i++) cfg[i] = d[i];
    pix_q.delete();
    for (int k = 0; k < 2 * PB; k++) pix_q.push_back(8'(8'hA0 + k));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed / random sequence ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 13; i++) cfg[i] = 8'h00;
    mon_clear();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_csx", 32'(csx), 1);
    chk("rst_wrx", 32'(wrx), 1);
    chk("rst_dcx", 32'(dcx), 1);
    chk("rst_d", 32'(dbus), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdy", 32'(pxl_rdy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Full frame with the reference configuration, pixels always valid.
    set_cfg_default();
    do_frame(-1, 0, 1'b0, 1'b0);

    // Stall before the third pixel, mid-frame mem-write rewrite, second start edge while busy.
    set_cfg_default();
    do_frame(2, 5, 1'b1, 1'b1);
    chk("mwr_code_unchanged", (edges.size() > 12) ? 32'(edges[12]) : 32'hFFFF, 32'h02C);

`ifdef DBI_TX_CONTINUOUS_EN
    // Start held through two frames: second frame is mem-write + pixels only.
    set_cfg_default();
    exp_q.delete();
    build_exp(0, 1'b1);
    build_exp(PB, 1'b0);
    mon_clear();
    src_idx = 0; hs_cnt = 0; stall_at = -1; stall_left = 0;
    start = 1'b1;
    wait_done(1);
    start = 1'b0;
    wait_done(2);
    repeat (30) @(posedge clk);
    #2;
    check_stream(2 * PB, 2 * PB, 2);
`else
    // Start held high across DONE must not start another frame.
    set_cfg_default();
    exp_q.delete();
    build_exp(0, 1'b1);
    mon_clear();
    src_idx = 0; hs_cnt = 0; stall_at = -1; stall_left = 0;
    start = 1'b1;
    wait_done(1);
    repeat (40) @(posedge clk);
    #2;
    check_stream(PB, PB, 1);
    start = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #2;

    // Randomized frames: random config, pixels, stall position/length, mid-frame rewrite.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 13; i++) cfg[i] = 8'($urandom_range(0, 255));
      pix_q.delete();
      for (int k = 0; k < PB; k++) pix_q.push_back(8'($urandom_range(0, 255)));
      do_frame(int'($urandom_range(0, PB - 1)), int'($urandom_range(0, 6)),
               1'($urandom_range(0, 1)), 1'b1);
    end

    // Asynchronous reset mid-frame: outputs return to idle without waiting for a clock.
    set_cfg_default();
    src_idx = 0;
    start = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_csx", 32'(csx), 1);
    chk("arst_wrx", 32'(wrx), 1);
    chk("arst_dcx", 32'(dcx), 1);
    chk("arst_d", 32'(dbus), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_rdy", 32'(pxl_rdy), 0);
    @(posedge clk);
    #2;
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    set_cfg_default();
    do_frame(1, 3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
